// File: rtl/mini_proc_pkg.sv
// Shared types and constants for the mini processor sequencer and its datapath.
package mini_proc_pkg;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned CTRL_W  = 2;
  localparam int unsigned INSTR_W = 8;

  localparam int unsigned HALT_BIT = 7;
  localparam int unsigned LOAD_BIT = 6;
  localparam int unsigned CTRL_MSB = 5;
  localparam int unsigned CTRL_LSB = 4;
  localparam int unsigned IMM_MSB  = 3;
  localparam int unsigned IMM_LSB  = 0;

  localparam logic [CTRL_W-1:0] OP_ADD = 2'b00;
  localparam logic [CTRL_W-1:0] OP_SUB = 2'b01;
  localparam logic [CTRL_W-1:0] OP_AND = 2'b10;
  localparam logic [CTRL_W-1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic              halt;
    logic              load;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] imm;
  } instr_t;

  // Split a raw program word into its fields.
  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.halt = w[HALT_BIT];
    d.load = w[LOAD_BIT];
    d.ctrl = w[CTRL_MSB:CTRL_LSB];
    d.imm  = w[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Operand/result bus between the sequencer and the 4-bit datapath.
interface alu_sequencer_if;
  import mini_proc_pkg::*;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_result;

  modport master (output alu_a, output alu_b, output alu_ctrl, input alu_result);
  modport slave  (input alu_a, input alu_b, input alu_ctrl, output alu_result);
endinterface

// File: rtl/prog_mem.sv
// Program store: one synchronous write port, one asynchronous read port, no reset.
module prog_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator-machine controller: fetches program words and drives the
// datapath operands, folding each result back into the accumulator.
module alu_sequencer
  import mini_proc_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [INSTR_W-1:0]  prog_data,
  alu_sequencer_if.master     dp,
  output logic [DATA_W-1:0]   acc,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                done
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  instr_t            instr_q, instr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [INSTR_W-1:0] mem_rdata;
  logic              mem_we;

  // Writes are only accepted while no program is running.
  assign mem_we = prog_we & ~busy_q;

  prog_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(INSTR_W)
  ) u_prog_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc_q),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      alu_a_q <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      alu_a_q <= alu_a_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    alu_a_d = alu_a_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          acc_d   = '0;
        end
      end
      ST_FETCH: begin
        instr_d = decode(mem_rdata);
        alu_a_d = acc_q;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (instr_q.halt) begin
          state_d = ST_DONE;
        end else begin
          acc_d = instr_q.load ? instr_q.imm : dp.alu_result;
          // Running off the end of memory finishes the program without wrapping.
          if (pc_q == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_DONE;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_FETCH) || (state_d == ST_EXEC);
    done_d = (state_d == ST_DONE);
  end

  // Operand B and the op select come straight from the latched instruction.
  assign dp.alu_a    = alu_a_q;
  assign dp.alu_b    = instr_q.imm;
  assign dp.alu_ctrl = instr_q.ctrl;
  assign acc         = acc_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural
// datapath and a program-level reference model.
module tb_alu_sequencer;
  import mini_proc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] acc;
  logic [3:0] pc;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_mem [16];

  alu_sequencer_if dp_if ();

  alu_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .dp       (dp_if),
    .acc      (acc),
    .pc       (pc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      OP_ADD:  return 4'(a + b);
      OP_SUB:  return 4'(a - b);
      OP_AND:  return a & b;
      default: return a | b;
    endcase
  endfunction

  // Downstream datapath stand-in.
  assign dp_if.alu_result = alu_fn(dp_if.alu_ctrl, dp_if.alu_a, dp_if.alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic write_all();
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = model_mem[i];
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
  endtask

  // Executes the stored program word by word; ops holds {a,b,ctrl} per instruction.
  task automatic ref_run(output logic [3:0] e_acc, output int e_pc, output int e_n,
                         output logic [9:0] ops [$]);
    logic [7:0] w;
    e_acc = 4'd0; e_pc = 0; e_n = 0;
    ops.delete();
    for (int p = 0; p < 16; p++) begin
      w = model_mem[p];
      e_pc = p;
      e_n++;
      ops.push_back({e_acc, w[3:0], w[5:4]});
      if (w[7]) break;
      if (w[6]) e_acc = w[3:0];
      else      e_acc = alu_fn(w[5:4], e_acc, w[3:0]);
    end
  endtask

  task automatic run_prog(input string tag, input bit inj_busy_we, input bit we_with_start,
                          input logic [7:0] w0);
    logic [3:0] e_acc;
    int         e_pc, e_n, cyc;
    logic [9:0] ops [$];
    logic [9:0] exp_op;
    if (we_with_start) model_mem[0] = w0;
    ref_run(e_acc, e_pc, e_n, ops);
    start = 1'b1;
    if (we_with_start) begin
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = w0;
    end
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      if (done) break;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (cyc % 2 == 0 && (cyc / 2 - 1) < ops.size()) begin
        exp_op = ops[cyc / 2 - 1];
        check({tag, "_alu_a"},    32'(dp_if.alu_a),    32'(exp_op[9:6]));
        check({tag, "_alu_b"},    32'(dp_if.alu_b),    32'(exp_op[5:2]));
        check({tag, "_alu_ctrl"}, 32'(dp_if.alu_ctrl), 32'(exp_op[1:0]));
      end
      if (inj_busy_we && cyc == 3) begin
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = ~model_mem[1];
      end else begin
        prog_we = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    prog_we = 1'b0;
    check({tag, "_done_cyc"}, 32'(cyc), 32'(2 * e_n + 1));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_acc"}, 32'(acc), 32'(e_acc));
    check({tag, "_pc"},  32'(pc),  32'(e_pc));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_acc_hold"},   32'(acc),  32'(e_acc));
    check({tag, "_pc_hold"},    32'(pc),   32'(e_pc));
  endtask

  task automatic fill_rand_from(input int first);
    for (int i = first; i < 16; i++) model_mem[i] = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [3:0] first_acc;
    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc",      32'(acc),            32'd0);
    check("rst_pc",       32'(pc),             32'd0);
    check("rst_busy",     32'(busy),           32'd0);
    check("rst_done",     32'(done),           32'd0);
    check("rst_alu_a",    32'(dp_if.alu_a),    32'd0);
    check("rst_alu_b",    32'(dp_if.alu_b),    32'd0);
    check("rst_alu_ctrl", 32'(dp_if.alu_ctrl), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LOAD 3, ADD 5, HALT
    model_mem[0] = 8'h43; model_mem[1] = 8'h05; model_mem[2] = 8'h80; fill_rand_from(3);
    write_all();
    run_prog("tp1", 1'b0, 1'b0, 8'h00);
    check("tp1_acc_const", 32'(acc), 32'd8);
    check("tp1_pc_const",  32'(pc),  32'd2);

    // LOAD 12, ADD 7, SUB 2, HALT: wraps modulo 16
    model_mem[0] = 8'h4C; model_mem[1] = 8'h07; model_mem[2] = 8'h12; model_mem[3] = 8'h80;
    fill_rand_from(4);
    write_all();
    run_prog("tp2", 1'b0, 1'b0, 8'h00);
    check("tp2_acc_const", 32'(acc), 32'd1);

    // LOAD F, AND 6, OR 1, HALT
    model_mem[0] = 8'h4F; model_mem[1] = 8'h26; model_mem[2] = 8'h31; model_mem[3] = 8'h80;
    fill_rand_from(4);
    write_all();
    run_prog("tp3", 1'b0, 1'b0, 8'h00);
    check("tp3_acc_const", 32'(acc), 32'd7);

    // No HALT: runs to the last entry and stops
    model_mem[0] = 8'h41;
    for (int i = 1; i < 16; i++) model_mem[i] = 8'h01;
    write_all();
    run_prog("tp4", 1'b0, 1'b0, 8'h00);
    check("tp4_acc_const", 32'(acc), 32'd0);
    check("tp4_pc_const",  32'(pc),  32'd15);

    // Write while busy is dropped; rerun matches
    model_mem[0] = 8'h43; model_mem[1] = 8'h05; model_mem[2] = 8'h80; fill_rand_from(3);
    write_all();
    run_prog("busy_we", 1'b1, 1'b0, 8'h00);
    first_acc = acc;
    run_prog("busy_rerun", 1'b0, 1'b0, 8'h00);
    check("busy_rerun_same", 32'(acc), 32'(first_acc));

    // Reset during EXEC of the second instruction
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_acc",   32'(acc),  32'd0);
    check("mid_pc",    32'(pc),   32'd0);
    check("mid_busy",  32'(busy), 32'd0);
    check("mid_done",  32'(done), 32'd0);
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("mid_no_done", 32'(pulses), 32'd0);
    run_prog("mid_restart", 1'b0, 1'b0, 8'h00);
    check("mid_restart_acc", 32'(acc), 32'd8);

    // Write to address 0 in the same cycle as start: LOAD 10 replaces LOAD 3
    run_prog("we_start", 1'b0, 1'b1, 8'h4A);
    check("we_start_acc", 32'(acc), 32'd15);

    // Random programs
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) begin
        model_mem[i] = 8'($urandom);
        if ($urandom_range(0, 5) != 0) model_mem[i][7] = 1'b0;
      end
      write_all();
      run_prog($sformatf("rnd%0d", t), 1'b0, 1'b0, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
